// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (P) has priority, the
// secondary return path (S) is queued in a FIFO with starvation-forced stall.
module regfile_wb_arbiter #(
  parameter int DWIDTH       = 32,
  parameter int AWIDTH       = 5,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 w_clk,
  input  logic                 w_rst,
  input  logic                 w_p_valid,
  input  logic [AWIDTH-1:0]    w_p_addr,
  input  logic [DWIDTH-1:0]    w_p_data,
  input  logic                 w_s_valid,
  output logic                 w_s_ready,
  input  logic [AWIDTH-1:0]    w_s_addr,
  input  logic [DWIDTH-1:0]    w_s_data,
  output logic                 w_wr_en,
  output logic [AWIDTH-1:0]    w_wr_addr,
  output logic [DWIDTH-1:0]    w_wr_data,
  output logic                 w_stall,
  output logic [2**AWIDTH-1:0] w_pend,
  output logic                 w_err
);

  // state | meaning
  // IDLE  | FIFO empty, age held at 0, no stall
  // WAIT  | head present, age counts cycles the head is denied
  // FORCE | stall asserted, head granted this cycle
  typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int AGEW = $clog2(STARVE_LIMIT + 1);

  logic [AWIDTH-1:0] mem_addr [DEPTH];
  logic [DWIDTH-1:0] mem_data [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count, count_nxt;
  logic [AGEW-1:0]   age, age_inc;
  state_t            state;

  logic              head_vld, full, push, grant_s, grant_p, grant;
  logic [AWIDTH-1:0] g_addr;
  logic [DWIDTH-1:0] g_data;

  assign head_vld  = (count != '0);
  assign full      = (count == CW'(DEPTH));
  assign w_s_ready = !full;
  assign push      = w_s_valid && !full;
  assign grant_s   = head_vld && (w_stall || !w_p_valid);
  assign grant_p   = w_p_valid && !w_stall;
  assign grant     = grant_s || grant_p;
  assign g_addr    = grant_s ? mem_addr[rd_ptr] : w_p_addr;
  assign g_data    = grant_s ? mem_data[rd_ptr] : w_p_data;
  assign age_inc   = age + AGEW'(1);

  always_comb begin
    count_nxt = count;
    case ({push, grant_s})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_comb begin
    w_pend = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count) w_pend[mem_addr[rd_ptr + PW'(k)]] = 1'b1;
    end
  end

  // Storage carries no reset; validity is tracked solely by count.
  always_ff @(posedge w_clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= w_s_addr;
      mem_data[wr_ptr] <= w_s_data;
    end
  end

  always_ff @(posedge w_clk) begin
    if (!w_rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      w_wr_en   <= 1'b0;
      w_wr_addr <= '0;
      w_wr_data <= '0;
      w_stall   <= 1'b0;
      w_err     <= 1'b0;
      age       <= '0;
      state     <= IDLE;
    end else begin
      if (push)    wr_ptr <= wr_ptr + PW'(1);
      if (grant_s) rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;

      // Writes to r0 are consumed but never reach the register file.
      w_wr_en <= grant && (g_addr != '0);
      if (grant) begin
        w_wr_addr <= g_addr;
        w_wr_data <= g_data;
      end
      if (w_p_valid && w_stall) w_err <= 1'b1;

      case (state)
        IDLE: begin
          age     <= '0;
          w_stall <= 1'b0;
          if (count_nxt != '0) state <= WAIT;
        end
        WAIT: begin
          if (count_nxt == '0) begin
            age   <= '0;
            state <= IDLE;
          end else if (grant_s) begin
            age <= '0;
          end else if (age_inc == AGEW'(STARVE_LIMIT)) begin
            age     <= age_inc;
            w_stall <= 1'b1;
            state   <= FORCE;
          end else begin
            age <= age_inc;
          end
        end
        FORCE: begin
          age     <= '0;
          w_stall <= 1'b0;
          state   <= (count_nxt != '0) ? WAIT : IDLE;
        end
        default: begin
          age     <= '0;
          w_stall <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios plus random traffic
// checked against a queue-based model of the arbitration rules.
module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic          w_clk, w_rst;
  logic          w_p_valid, w_s_valid, w_s_ready;
  logic [AW-1:0] w_p_addr, w_s_addr, w_wr_addr;
  logic [DW-1:0] w_p_data, w_s_data, w_wr_data;
  logic          w_wr_en, w_stall, w_err;
  logic [31:0]   w_pend;

  regfile_wb_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .w_clk(w_clk), .w_rst(w_rst),
    .w_p_valid(w_p_valid), .w_p_addr(w_p_addr), .w_p_data(w_p_data),
    .w_s_valid(w_s_valid), .w_s_ready(w_s_ready), .w_s_addr(w_s_addr), .w_s_data(w_s_data),
    .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
    .w_stall(w_stall), .w_pend(w_pend), .w_err(w_err)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  bit            m_stall, m_err, exp_en;
  int            m_age;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  int            errors = 0;
  int            checks = 0;

  function automatic logic [31:0] model_pend();
    logic [31:0] p = '0;
    foreach (q[i]) p[q[i].a] = 1'b1;
    return p;
  endfunction

  task automatic do_reset();
    w_rst = 1'b0; w_p_valid = 1'b0; w_s_valid = 1'b0;
    w_p_addr = '0; w_p_data = '0; w_s_addr = '0; w_s_data = '0;
    q.delete(); m_stall = 0; m_err = 0; m_age = 0; exp_en = 0;
    exp_addr = '0; exp_data = '0;
    @(posedge w_clk); #1;
    w_rst = 1'b1;
  endtask

  // Drive one cycle of stimulus and advance the model to the post-edge state.
  task automatic step(input logic pv, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                      input logic sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd);
    int   sz;
    bit   gs, gp;
    ent_t h;
    w_p_valid = pv; w_p_addr = pa; w_p_data = pd;
    w_s_valid = sv; w_s_addr = sa; w_s_data = sd;
    sz = q.size();
    gs = (sz > 0) && (m_stall || !pv);
    gp = pv && !m_stall;
    if (pv && m_stall) m_err = 1;
    exp_en = 0;
    if (gs) begin
      h = q.pop_front();
      exp_en = (h.a != 0); exp_addr = h.a; exp_data = h.d;
    end else if (gp) begin
      exp_en = (pa != 0); exp_addr = pa; exp_data = pd;
    end
    if (sv && sz < DEPTH) q.push_back('{sa, sd});
    if (m_stall) begin
      m_stall = 0; m_age = 0;
    end else if (sz > 0 && !gs) begin
      m_age++;
      if (m_age == LIMIT) begin m_stall = 1; m_age = 0; end
    end else begin
      m_age = 0;
    end
    @(posedge w_clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 7;
    if (w_wr_en !== 1'b0)   begin errors++; $display("FAIL rst_wr_en got=%b exp=0", w_wr_en); end
    if (w_wr_addr !== '0)   begin errors++; $display("FAIL rst_wr_addr got=%h exp=0", w_wr_addr); end
    if (w_wr_data !== '0)   begin errors++; $display("FAIL rst_wr_data got=%h exp=0", w_wr_data); end
    if (w_stall !== 1'b0)   begin errors++; $display("FAIL rst_stall got=%b exp=0", w_stall); end
    if (w_err !== 1'b0)     begin errors++; $display("FAIL rst_err got=%b exp=0", w_err); end
    if (w_pend !== 32'h0)   begin errors++; $display("FAIL rst_pend got=%h exp=0", w_pend); end
    if (w_s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready got=%b exp=1", w_s_ready); end
  endtask

  task automatic test_p_write();
    step(1'b1, 5'd3, 32'hAAAA_0001, 1'b0, '0, '0);
    checks += 5;
    if (w_wr_en !== 1'b1)          begin errors++; $display("FAIL p_wr_en got=%b exp=1", w_wr_en); end
    if (w_wr_addr !== 5'd3)        begin errors++; $display("FAIL p_wr_addr got=%h exp=3", w_wr_addr); end
    if (w_wr_data !== 32'hAAAA_0001) begin errors++; $display("FAIL p_wr_data got=%h exp=aaaa0001", w_wr_data); end
    if (w_stall !== 1'b0)          begin errors++; $display("FAIL p_stall got=%b exp=0", w_stall); end
    if (w_pend !== 32'h0)          begin errors++; $display("FAIL p_pend got=%h exp=0", w_pend); end
  endtask

  task automatic test_s_single();
    step(1'b0, '0, '0, 1'b1, 5'd7, 32'h77);
    checks += 2;
    if (w_pend !== 32'h80) begin errors++; $display("FAIL s1_pend_set got=%h exp=00000080", w_pend); end
    if (w_wr_en !== 1'b0)  begin errors++; $display("FAIL s1_early_wr got=%b exp=0", w_wr_en); end
    step(1'b0, '0, '0, 1'b0, '0, '0);
    checks += 4;
    if (w_wr_en !== 1'b1)      begin errors++; $display("FAIL s1_wr_en got=%b exp=1", w_wr_en); end
    if (w_wr_addr !== 5'd7)    begin errors++; $display("FAIL s1_wr_addr got=%h exp=7", w_wr_addr); end
    if (w_wr_data !== 32'h77)  begin errors++; $display("FAIL s1_wr_data got=%h exp=77", w_wr_data); end
    if (w_pend !== 32'h0)      begin errors++; $display("FAIL s1_pend_clr got=%h exp=0", w_pend); end
  endtask

  task automatic test_starve();
    logic [AW-1:0] first_a;
    int pushed = 0;
    int stall_step = -1;
    do_reset();
    first_a = AW'($urandom_range(1, 31));
    for (int j = 0; j < 40 && stall_step < 0; j++) begin
      step(!m_stall, AW'($urandom_range(1, 31)), $urandom,
           pushed < DEPTH, (pushed == 0) ? first_a : AW'($urandom_range(1, 31)), $urandom);
      if (pushed < DEPTH) pushed++;
      if (j == DEPTH - 1) begin
        checks++;
        if (w_s_ready !== 1'b0) begin errors++; $display("FAIL starve_full_ready got=%b exp=0", w_s_ready); end
      end
      checks++;
      if (w_stall !== m_stall) begin errors++; $display("FAIL starve_stall step=%0d got=%b exp=%b", j, w_stall, m_stall); end
      if (w_stall === 1'b1) stall_step = j;
    end
    checks++;
    if (stall_step != LIMIT) begin errors++; $display("FAIL starve_stall_step got=%0d exp=%0d", stall_step, LIMIT); end
    step(1'b0, '0, '0, 1'b0, '0, '0);
    checks += 3;
    if (w_wr_en !== 1'b1)     begin errors++; $display("FAIL starve_head_en got=%b exp=1", w_wr_en); end
    if (w_wr_addr !== first_a) begin errors++; $display("FAIL starve_head_addr got=%h exp=%h", w_wr_addr, first_a); end
    if (w_err !== 1'b0)       begin errors++; $display("FAIL starve_err got=%b exp=0", w_err); end
  endtask

  task automatic test_err();
    int guard = 0;
    while (!m_stall && guard < 20) begin
      step(1'b1, AW'($urandom_range(1, 31)), $urandom, 1'b0, '0, '0);
      guard++;
    end
    checks++;
    if (w_stall !== 1'b1) begin errors++; $display("FAIL err_reach_stall got=%b exp=1", w_stall); end
    step(1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0, '0, '0);
    checks += 4;
    if (w_wr_data === 32'hDEAD_BEEF) begin errors++; $display("FAIL err_p_dropped got=%h exp=not deadbeef", w_wr_data); end
    if (w_wr_en !== exp_en)   begin errors++; $display("FAIL err_wr_en got=%b exp=%b", w_wr_en, exp_en); end
    if (exp_en && w_wr_addr !== exp_addr) begin errors++; $display("FAIL err_wr_addr got=%h exp=%h", w_wr_addr, exp_addr); end
    if (w_err !== 1'b1)       begin errors++; $display("FAIL err_set got=%b exp=1", w_err); end
    for (int j = 0; j < 5; j++) begin
      step(1'b0, '0, '0, 1'b0, '0, '0);
      checks++;
      if (w_err !== 1'b1) begin errors++; $display("FAIL err_sticky step=%0d got=%b exp=1", j, w_err); end
    end
  endtask

  task automatic test_addr0();
    do_reset();
    step(1'b0, '0, '0, 1'b1, 5'd0, 32'h55);
    checks += 2;
    if (w_pend !== 32'h1) begin errors++; $display("FAIL a0_pend_set got=%h exp=1", w_pend); end
    if (w_wr_en !== 1'b0) begin errors++; $display("FAIL a0_wr_en0 got=%b exp=0", w_wr_en); end
    step(1'b0, '0, '0, 1'b0, '0, '0);
    checks += 2;
    if (w_wr_en !== 1'b0) begin errors++; $display("FAIL a0_wr_en1 got=%b exp=0", w_wr_en); end
    if (w_pend !== 32'h0) begin errors++; $display("FAIL a0_pend_clr got=%h exp=0", w_pend); end
  endtask

  task automatic test_flush();
    step(1'b1, 5'd4, 32'h4444, 1'b1, 5'd11, 32'hB0B0);
    step(1'b1, 5'd5, 32'h5555, 1'b1, 5'd12, 32'hC0C0);
    checks++;
    if (w_pend !== 32'h1800) begin errors++; $display("FAIL fl_pend_pre got=%h exp=00001800", w_pend); end
    do_reset();
    checks += 5;
    if (w_wr_en !== 1'b0)  begin errors++; $display("FAIL fl_wr_en got=%b exp=0", w_wr_en); end
    if (w_wr_addr !== '0)  begin errors++; $display("FAIL fl_wr_addr got=%h exp=0", w_wr_addr); end
    if (w_wr_data !== '0)  begin errors++; $display("FAIL fl_wr_data got=%h exp=0", w_wr_data); end
    if (w_pend !== 32'h0)  begin errors++; $display("FAIL fl_pend got=%h exp=0", w_pend); end
    if (w_stall !== 1'b0 || w_err !== 1'b0) begin errors++; $display("FAIL fl_stall_err got=%b%b exp=00", w_stall, w_err); end
    for (int j = 0; j < 6; j++) begin
      step(1'b0, '0, '0, 1'b0, '0, '0);
      checks++;
      if (w_wr_en !== 1'b0) begin errors++; $display("FAIL fl_no_write step=%0d got=%b exp=0", j, w_wr_en); end
    end
  endtask

  task automatic test_random();
    int p_pct;
    do_reset();
    for (int j = 0; j < 600; j++) begin
      p_pct = ((j / 100) % 2 == 0) ? 90 : 40;
      step(!m_stall && ($urandom_range(0, 99) < p_pct), AW'($urandom_range(0, 31)), $urandom,
           $urandom_range(0, 1) == 1, AW'($urandom_range(0, 31)), $urandom);
      checks += 5;
      if (w_wr_en !== exp_en)  begin errors++; $display("FAIL rnd_wr_en step=%0d got=%b exp=%b", j, w_wr_en, exp_en); end
      if (w_stall !== m_stall) begin errors++; $display("FAIL rnd_stall step=%0d got=%b exp=%b", j, w_stall, m_stall); end
      if (w_pend !== model_pend()) begin errors++; $display("FAIL rnd_pend step=%0d got=%h exp=%h", j, w_pend, model_pend()); end
      if (w_s_ready !== (q.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready step=%0d got=%b exp=%b", j, w_s_ready, q.size() < DEPTH); end
      if (w_err !== m_err)     begin errors++; $display("FAIL rnd_err step=%0d got=%b exp=%b", j, w_err, m_err); end
      if (exp_en) begin
        checks++;
        if (w_wr_addr !== exp_addr || w_wr_data !== exp_data)
          begin errors++; $display("FAIL rnd_wr step=%0d got=%h/%h exp=%h/%h", j, w_wr_addr, w_wr_data, exp_addr, exp_data); end
      end
    end
  endtask

  initial begin
    w_rst = 1'b0; w_p_valid = 1'b0; w_s_valid = 1'b0;
    w_p_addr = '0; w_p_data = '0; w_s_addr = '0; w_s_data = '0;
    test_reset();
    test_p_write();
    test_s_single();
    test_starve();
    test_err();
    test_addr0();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two requesters.
  - P: the pipeline writeback stage. Highest priority, never back-pressured.
  - S: the secondary multi-cycle writeback source (load-miss / mul-div return), buffered in a small FIFO.
- Drives the register file write port (wr_en/addr/data) from registered outputs.
- Raises a stall request when S is starved.
- Exports a pending-write mask so decode can detect hazards against queued S writes.

Parameters:
- DWIDTH, 32, data width; matches `DWIDTH.
- AWIDTH, 5, register address width; matches `AWIDTH.
- DEPTH, 4, S FIFO entries; power of two, ≥2.
- STARVE_LIMIT, 8, consecutive cycles a non-empty FIFO head may be denied before a forced stall.

Ports:
- w_clk  in  1  clock; all state updates on posedge.
- w_rst  in  1  synchronous active-low reset.
- w_p_valid  in  1  P write request this cycle.
- w_p_addr  in  AWIDTH  P destination register.
- w_p_data  in  DWIDTH  P write data.
- w_s_valid  in  1  S offers an entry.
- w_s_ready  out  1  FIFO can accept; equals !full.
- w_s_addr  in  AWIDTH  S destination register.
- w_s_data  in  DWIDTH  S write data.
- w_wr_en  out  1  to register file write enable.
- w_wr_addr  out  AWIDTH  to register file write address.
- w_wr_data  out  DWIDTH  to register file write data.
- w_stall  out  1  request to freeze the pipeline; P must hold w_p_valid=0 while high.
- w_pend  out  2**AWIDTH  bit n=1 when any valid FIFO entry targets register n.
- w_err  out  1  sticky; P write arrived while w_stall=1.

Behaviour:
- Reset (w_rst=0 at posedge):
  - FIFO flushed and queued writes discarded; pointers and count set to 0.
  - w_wr_en=0, w_wr_addr=0, w_wr_data=0, w_stall=0, w_err=0, FSM=IDLE.
  - Reset mid-operation has the same effect; any in-flight S entry is lost.
- S handshake:
  - Transfer occurs when w_s_valid & w_s_ready at posedge.
  - No bypass: an entry is enqueued first and becomes the head the next cycle at the earliest.
  - A push is never possible when full because w_s_ready=0.
- Grant, evaluated each cycle from current state:
  - w_stall=1 and FIFO non-empty → S head.
  - Else w_p_valid=1 → P.
  - Else FIFO non-empty → S head.
  - Else none.
- Granted write is registered: w_wr_en/addr/data valid in the following cycle.
  - P latency: 1 cycle.
  - S minimum latency from handshake: 2 cycles.
- Address 0: a granted write with addr 0 is consumed (FIFO pops / P accepted) but w_wr_en stays 0.
- Pop and push in the same cycle are allowed; count unchanged.
- w_pend is combinational from valid FIFO entries.
  - An entry's bit clears in the cycle after it pops.
  - Duplicate addresses keep the bit set until the last matching entry pops.
- Ordering: commits occur in grant order. WAW/RAW avoidance against queued entries is the pipeline's responsibility via w_pend.
- Age/stall FSM (age counter, width clog2(STARVE_LIMIT+1)):
  - IDLE: FIFO empty, age=0, w_stall=0. Goes to WAIT when FIFO becomes non-empty.
  - WAIT:
    - Age increments each cycle the head is present and not granted.
    - Age resets to 0 on head grant.
    - Goes to IDLE when FIFO becomes empty.
    - Goes to FORCE when age reaches STARVE_LIMIT; w_stall=1 from that next cycle.
  - FORCE:
    - w_stall=1 and the head is granted.
    - Next cycle: age=0, w_stall=0, to WAIT if the FIFO is still non-empty, else IDLE.
- Error: w_p_valid=1 while w_stall=1 → P write dropped and w_err set; w_err clears only on reset.

Test Plan:
- After reset, P writes addr 3 data 0xAAAA_0001 in cycle t → w_wr_en=1, addr 3, data 0xAAAA_0001 in t+1; w_stall=0, w_pend=0.
- S pushes (7, 0x77) with P idle → w_pend[7]=1 at t+1; write commits at t+2; w_pend[7]=0 at t+2.
- Fill FIFO with 4 S entries while P continuously valid:
  - w_s_ready=0 when full.
  - w_stall=1 after 8 denied cycles; head commits in the following cycle.
  - P held low as required → w_err=0.
- Drive w_p_valid=1 during w_stall=1 → P data absent from the write port; w_err=1 and stays 1 until reset.
- S push to addr 0 → entry pops with w_wr_en=0; w_pend[0] cycles 1 then 0.
- Two queued entries, then w_rst=0 for one cycle:
  - All outputs 0 next cycle; w_pend=0.
  - No write ever issued for the flushed entries.
